race_sequencer: RTL
===================

# race_sequencer

Top-level game-flow controller for the two-car race. It generates the shared 60 Hz game tick and drives the 3-bit `state` bus consumed by both physics engines, whose motion runs only in state 4. It also issues a one-cycle synchronous reset pulse to the engines, runs the start countdown, counts laps per player, times the race and declares the winner.

## Interface
Parameters:
- `CLK_FREQ`, 100_000_000: system clock, Hz.
- `TICK_HZ`, 60: game tick rate. TICK_LIMIT = CLK_FREQ / TICK_HZ cycles per tick.
- `COUNTDOWN_SEC`, 3: countdown length in seconds, range 1..3.
- `LAPS`, 3: laps to win, range 1..7.
- `FINISH_HOLD_TICKS`, 180: ticks spent in FINISH before auto-return to IDLE.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start_btn`  in  1  debounced, synchronized level.
- `pause_btn`  in  1  debounced, synchronized level.
- `p1_lap`, `p2_lap`  in  1  each  finish-line crossing level from checkpoint logic, one per player.
- `state`  out  3  0 IDLE, 1 CARS_RST, 2 COUNTDOWN, 3 PAUSE, 4 RACE, 5 FINISH.
- `game_tick`  out  1  one-cycle pulse every TICK_LIMIT cycles.
- `engine_rst`  out  1  active-high reset to both physics engines.
- `countdown_val`  out  2  seconds remaining; 0 outside COUNTDOWN.
- `p1_laps`, `p2_laps`  out  3  each  completed laps per player.
- `winner`  out  2  0 none, 1 P1, 2 P2, 3 tie.
- `race_time`  out  16  race duration in ticks.

## Operation
- **Input edge detection:** all four inputs are rising-edge detected against a registered previous value. Only edges act; held levels never repeat an action.
- **Tick counter:** `tick_cnt` counts 0..TICK_LIMIT-1 and wraps.
  - `game_tick` = (`tick_cnt` == TICK_LIMIT-1). It is free-running in every state.
- **IDLE:** a start edge moves to CARS_RST.
- **CARS_RST:** lasts exactly one cycle.
  - `engine_rst` = 1.
  - Clears the lap counters, `winner` and `race_time`.
  - Loads `countdown_val` = COUNTDOWN_SEC and clears the sub-second tick counter `sub_cnt`.
  - Next state: COUNTDOWN.
- **COUNTDOWN:**
  - On each tick, `sub_cnt` increments.
  - At `sub_cnt` == TICK_HZ-1 with a tick, `sub_cnt` clears and `countdown_val` decrements.
  - The decrement from 1 goes to RACE, with `countdown_val` = 0.
  - Start, pause and lap edges are ignored.
- **RACE:**
  - `race_time` increments on each tick and saturates at 0xFFFF.
  - A lap edge increments that player's counter, saturating at LAPS.
  - When a lap edge brings a counter to LAPS, the state goes to FINISH and `winner` is set to that player.
  - Both players reaching LAPS in the same cycle sets `winner` = 3.
  - A pause edge goes to PAUSE. If a pause edge and a winning lap edge arrive in the same cycle, the win takes priority.
- **PAUSE:**
  - Counters, `race_time` and `sub_cnt` are frozen.
  - Lap and start edges are ignored.
  - A pause edge returns to RACE.
- **FINISH:**
  - Holds `winner`, the lap counters and `race_time`.
  - Counts ticks; after FINISH_HOLD_TICKS ticks it goes to IDLE. `winner` persists until the next CARS_RST.
  - A start edge goes straight to CARS_RST (rematch).
- **Illegal `state` codes 6 and 7:** next state is IDLE.

## Timing
- **Reset values:** every output and internal register is 0 during reset, including `state` = IDLE and `engine_rst` = 0. The edge-detect history also resets to 0, so an input already high at reset release counts as an edge.
- **Outputs:** all registered except `game_tick`, which is decoded from the `tick_cnt` register. There is no combinational input-to-output path.
- **Input latency:** an input edge at cycle N is captured by the history register, so the state or counter update is visible at N+1.
- **Win timing:** the winning lap counter and the FINISH state update in the same cycle.
- **First tick:** `game_tick` first asserts TICK_LIMIT cycles after reset release, then has a period of exactly TICK_LIMIT.
- **Countdown duration:** from entering COUNTDOWN to RACE is COUNTDOWN_SEC × TICK_HZ ticks, ±1 tick of phase.
- **Engine reset:** `engine_rst` pulse width is exactly 1 cycle.
- **Reset mid-operation:** asynchronous return to IDLE. No `engine_rst` pulse is generated.

## Configuration
- **`RACE_PAUSE_EN` defined:** `pause_btn` is active and the PAUSE state is reachable, as described above.
- **`RACE_PAUSE_EN` undefined:**
  - `pause_btn` is ignored and its edge detector is not built.
  - PAUSE is unreachable; code 3 is treated as illegal and goes to IDLE.

## Test plan
All scenarios use CLK_FREQ=600, TICK_HZ=60, which gives TICK_LIMIT=10 and TICK_HZ=60 ticks per second.
- **Tick period:** release reset → `game_tick` high at cycles 10, 20, 30, each for 1 cycle. All outputs are 0 while `rst` is low.
- **Start and countdown:** start edge in IDLE → `state`=1 with `engine_rst`=1 for 1 cycle, then `state`=2 with `countdown_val`=3. `countdown_val` steps 3→2→1 every 60 ticks. After 180 ticks, `state`=4 and `countdown_val`=0.
- **Race win (LAPS=3):** in RACE, give p1 three lap edges and p2 two → `p1_laps`=3, `state`=5, `winner`=1, `race_time` frozen. Holding `p1_lap` high gives only one increment.
- **Tie:** with both players at 2 laps, assert `p1_lap` and `p2_lap` edges in the same cycle → `winner`=3, `state`=5.
- **Pause (`RACE_PAUSE_EN` defined):**
  - Pause edge → `state`=3; `race_time` is unchanged over 50 ticks and lap edges are ignored.
  - Second pause edge → `state`=4 and timing resumes.
  - Repeat with the macro undefined → `state` stays 4.
- **Finish exit and reset mid-race:**
  - After 180 ticks in FINISH → `state`=0.
  - A start edge in FINISH → `state`=1 immediately.
  - Asserting `rst` low during COUNTDOWN → all outputs 0 asynchronously.

Source files
------------

// File: rtl/race_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer_if
// Description : Bundle of the race sequencer's player inputs and game-flow
//               outputs. The 'slave' modport is the sequencer's view and
//               the 'master' modport is the view of the logic that drives
//               the buttons and consumes the game state.
// Signals     : start_btn, pause_btn, p1_lap, p2_lap   (master -> slave)
//               state[2:0], game_tick, engine_rst,
//               countdown_val[1:0], p1_laps[2:0], p2_laps[2:0],
//               winner[1:0], race_time[15:0]        (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface race_sequencer_if;
    logic        start_btn;
    logic        pause_btn;
    logic        p1_lap;
    logic        p2_lap;
    logic [2:0]  state;
    logic        game_tick;
    logic        engine_rst;
    logic [1:0]  countdown_val;
    logic [2:0]  p1_laps;
    logic [2:0]  p2_laps;
    logic [1:0]  winner;
    logic [15:0] race_time;

    modport master (
        output start_btn, pause_btn, p1_lap, p2_lap,
        input  state, game_tick, engine_rst, countdown_val,
        input  p1_laps, p2_laps, winner, race_time
    );

    modport slave (
        input  start_btn, pause_btn, p1_lap, p2_lap,
        output state, game_tick, engine_rst, countdown_val,
        output p1_laps, p2_laps, winner, race_time
    );
endinterface
`default_nettype wire

// File: rtl/race_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : race_sequencer
// Description : Game-flow controller for the two-car race. Generates the
//               free-running game tick, sequences IDLE -> CARS_RST ->
//               COUNTDOWN -> RACE -> FINISH, pulses the engine reset,
//               counts laps, times the race and declares the winner.
// Ports       : clk   - system clock
//               rst_n - asynchronous active-low reset
//               bus   - race_sequencer_if.slave (buttons in, game state out)
// Options     : RACE_PAUSE_EN - when defined, pause_btn toggles between
//               RACE and PAUSE; otherwise pause is not built and state
//               code 3 is treated as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module race_sequencer #(
    parameter int unsigned CLK_FREQ          = 100_000_000,
    parameter int unsigned TICK_HZ           = 60,
    parameter int unsigned COUNTDOWN_SEC     = 3,
    parameter int unsigned LAPS              = 3,
    parameter int unsigned FINISH_HOLD_TICKS = 180
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    race_sequencer_if.slave   bus
);

    localparam int unsigned C_TICK_LIMIT = CLK_FREQ / TICK_HZ;
    localparam int unsigned C_TICK_W     = (C_TICK_LIMIT > 1) ? $clog2(C_TICK_LIMIT) : 1;
    localparam int unsigned C_SUB_W      = (TICK_HZ > 1) ? $clog2(TICK_HZ) : 1;
    localparam int unsigned C_HOLD_W     = (FINISH_HOLD_TICKS > 1) ? $clog2(FINISH_HOLD_TICKS) : 1;

    localparam logic [C_TICK_W-1:0] C_TICK_MAX = C_TICK_W'(C_TICK_LIMIT - 1);
    localparam logic [C_SUB_W-1:0]  C_SUB_MAX  = C_SUB_W'(TICK_HZ - 1);
    localparam logic [C_HOLD_W-1:0] C_HOLD_MAX = C_HOLD_W'(FINISH_HOLD_TICKS - 1);
    localparam logic [1:0]          C_CD_LOAD  = 2'(COUNTDOWN_SEC);
    localparam logic [2:0]          C_LAPS     = 3'(LAPS);
    localparam logic [2:0]          C_LAPS_M1  = 3'(LAPS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CARS_RST  = 3'd1,
        ST_COUNTDOWN = 3'd2,
        ST_PAUSE     = 3'd3,
        ST_RACE      = 3'd4,
        ST_FINISH    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [C_TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [C_SUB_W-1:0]  sub_cnt_q, sub_cnt_d;
    logic [C_HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]          countdown_q, countdown_d;
    logic [2:0]          p1_laps_q, p1_laps_d;
    logic [2:0]          p2_laps_q, p2_laps_d;
    logic [1:0]          winner_q, winner_d;
    logic [15:0]         race_time_q, race_time_d;
    logic                engine_rst_q, engine_rst_d;

    logic                start_prev_q;
    logic                p1_prev_q;
    logic                p2_prev_q;

    logic                w_tick;
    logic                w_start_edge;
    logic                w_p1_edge;
    logic                w_p2_edge;
    logic                w_pause_edge;
    logic                w_p1_hit;
    logic                w_p2_hit;
    logic                w_p1_win;
    logic                w_p2_win;

    // ------------------------------------------------------------------
    // Free-running tick divider; game_tick is a decode of the register.
    // ------------------------------------------------------------------
    assign w_tick     = (tick_cnt_q == C_TICK_MAX);
    assign tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;

    // ------------------------------------------------------------------
    // Rising-edge detection. History resets to 0 so a level already high
    // at reset release is treated as a fresh press.
    // ------------------------------------------------------------------
    assign w_start_edge = bus.start_btn & ~start_prev_q;
    assign w_p1_edge    = bus.p1_lap    & ~p1_prev_q;
    assign w_p2_edge    = bus.p2_lap    & ~p2_prev_q;

`ifdef RACE_PAUSE_EN
    logic pause_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_prev_q <= 1'b0;
        end else begin
            pause_prev_q <= bus.pause_btn;
        end
    end

    assign w_pause_edge = bus.pause_btn & ~pause_prev_q;
`else
    logic w_unused_pause;
    assign w_unused_pause = bus.pause_btn;
    assign w_pause_edge   = 1'b0;
`endif

    // A lap only counts while below the target; the edge that reaches
    // the target is the winning one.
    assign w_p1_hit = w_p1_edge && (p1_laps_q < C_LAPS);
    assign w_p2_hit = w_p2_edge && (p2_laps_q < C_LAPS);
    assign w_p1_win = w_p1_hit && (p1_laps_q == C_LAPS_M1);
    assign w_p2_win = w_p2_hit && (p2_laps_q == C_LAPS_M1);

    // ------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sub_cnt_d   = sub_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        countdown_d = countdown_q;
        p1_laps_d   = p1_laps_q;
        p2_laps_d   = p2_laps_q;
        winner_d    = winner_q;
        race_time_d = race_time_q;

        case (state_q)
            ST_IDLE: begin
                if (w_start_edge) begin
                    state_d = ST_CARS_RST;
                end
            end

            ST_CARS_RST: begin
                p1_laps_d   = '0;
                p2_laps_d   = '0;
                winner_d    = '0;
                race_time_d = '0;
                countdown_d = C_CD_LOAD;
                sub_cnt_d   = '0;
                state_d     = ST_COUNTDOWN;
            end

            ST_COUNTDOWN: begin
                if (w_tick) begin
                    if (sub_cnt_q == C_SUB_MAX) begin
                        sub_cnt_d   = '0;
                        countdown_d = countdown_q - 2'd1;
                        // Leaving the last second lands exactly on 0.
                        if (countdown_q == 2'd1) begin
                            state_d = ST_RACE;
                        end
                    end else begin
                        sub_cnt_d = sub_cnt_q + 1'b1;
                    end
                end
            end

            ST_RACE: begin
                if (w_tick && (race_time_q != 16'hFFFF)) begin
                    race_time_d = race_time_q + 16'd1;
                end
                if (w_p1_hit) begin
                    p1_laps_d = p1_laps_q + 3'd1;
                end
                if (w_p2_hit) begin
                    p2_laps_d = p2_laps_q + 3'd1;
                end
                // winner encoding {P2,P1} gives 1, 2, or 3 for a tie.
                if (w_p1_win || w_p2_win) begin
                    winner_d   = {w_p2_win, w_p1_win};
                    hold_cnt_d = '0;
                    state_d    = ST_FINISH;
                end else if (w_pause_edge) begin
                    state_d = ST_PAUSE;
                end
            end

`ifdef RACE_PAUSE_EN
            ST_PAUSE: begin
                if (w_pause_edge) begin
                    state_d = ST_RACE;
                end
            end
`endif

            ST_FINISH: begin
                if (w_start_edge) begin
                    state_d = ST_CARS_RST;
                end else if (w_tick) begin
                    if (hold_cnt_q == C_HOLD_MAX) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered alongside the state so it is high exactly while
        // the state reads CARS_RST.
        engine_rst_d = (state_d == ST_CARS_RST);
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            sub_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            countdown_q  <= '0;
            p1_laps_q    <= '0;
            p2_laps_q    <= '0;
            winner_q     <= '0;
            race_time_q  <= '0;
            engine_rst_q <= 1'b0;
            start_prev_q <= 1'b0;
            p1_prev_q    <= 1'b0;
            p2_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            sub_cnt_q    <= sub_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            countdown_q  <= countdown_d;
            p1_laps_q    <= p1_laps_d;
            p2_laps_q    <= p2_laps_d;
            winner_q     <= winner_d;
            race_time_q  <= race_time_d;
            engine_rst_q <= engine_rst_d;
            start_prev_q <= bus.start_btn;
            p1_prev_q    <= bus.p1_lap;
            p2_prev_q    <= bus.p2_lap;
        end
    end

    assign bus.state         = state_q;
    assign bus.game_tick     = w_tick;
    assign bus.engine_rst    = engine_rst_q;
    assign bus.countdown_val = countdown_q;
    assign bus.p1_laps       = p1_laps_q;
    assign bus.p2_laps       = p2_laps_q;
    assign bus.winner        = winner_q;
    assign bus.race_time     = race_time_q;

endmodule
`default_nettype wire
